// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller: phase encoding,
// colour indices and default timing parameters.
package simon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int NUM_BTNS = 4;
  localparam int COLOR_W  = 2;
  localparam int SCORE_W  = 4;

  localparam logic [COLOR_W-1:0] CLR_0 = 2'd0;
  localparam logic [COLOR_W-1:0] CLR_1 = 2'd1;
  localparam logic [COLOR_W-1:0] CLR_2 = 2'd2;
  localparam logic [COLOR_W-1:0] CLR_3 = 2'd3;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  localparam int DEBOUNCE_TICKS_DEF = 3;
  localparam int OVER_HOLD_DEF      = 180;

  function automatic logic is_onehot(input logic [NUM_BTNS-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Only meaningful for one-hot inputs; anything else maps to colour 0.
  function automatic logic [COLOR_W-1:0] onehot_index(input logic [NUM_BTNS-1:0] v);
    logic [COLOR_W-1:0] idx;
    case (v)
      4'b0010: idx = CLR_1;
      4'b0100: idx = CLR_2;
      4'b1000: idx = CLR_3;
      default: idx = CLR_0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a per-bit debouncer: the output level
// follows the synchronized input only after TICKS consecutive differing samples.
module btn_debounce #(
  parameter int WIDTH = 4,
  parameter int TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  localparam logic [3:0] LAST = 4'(TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level_q;
  logic [3:0]       cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample agreeing with the accepted level restarts the run.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == level_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          level_q[i] <= sync2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game phase controller: debounces player/start buttons, gates press
// events to the player's turn, tracks score and sequences IDLE/START/PLAY/OVER.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int OVER_HOLD      = OVER_HOLD_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_btn,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic                simon_turn,
  input  logic                simon_game_over,
  output logic                simon_reset,
  output logic [COLOR_W-1:0]  player_num,
  output logic                player_pressed,
  output logic [1:0]          state,
  output logic [SCORE_W-1:0]  score
);

  localparam int              HOLD_W    = $clog2(OVER_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD - 1);

  logic [NUM_BTNS-1:0] btn_lvl;
  logic [0:0]          start_lvl;

  btn_debounce #(.WIDTH(NUM_BTNS), .TICKS(DEBOUNCE_TICKS)) u_btn_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn),
    .level (btn_lvl)
  );

  btn_debounce #(.WIDTH(1), .TICKS(DEBOUNCE_TICKS)) u_start_db (
    .clk   (clk),
    .reset (reset),
    .raw   (start_btn),
    .level (start_lvl)
  );

  state_t              state_q, state_d;
  logic [NUM_BTNS-1:0] btn_prev;
  logic                start_prev;
  logic                turn_prev;
  logic [SCORE_W-1:0]  score_q;
  logic [COLOR_W-1:0]  num_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_done;

  logic start_edge;
  logic press_evt;
  logic accept;

  // A press only counts when leaving the all-released vector, so chords and
  // their partial releases never generate events.
  assign start_edge = start_lvl[0] & ~start_prev;
  assign press_evt  = (btn_prev == '0) && is_onehot(btn_lvl);
  assign accept     = press_evt && (state_q == ST_PLAY) && !simon_turn;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_START;
      ST_START: state_d = ST_PLAY;
      ST_PLAY:  if (simon_game_over) state_d = ST_OVER;
      ST_OVER:  if (start_edge && hold_done) state_d = ST_START;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    simon_reset    = 1'b0;
    player_pressed = accept;
    player_num     = num_q;
    if (state_q == ST_IDLE || state_q == ST_START) simon_reset = 1'b1;
    if (accept) player_num = onehot_index(btn_lvl);
  end

  assign state = state_q;
  assign score = score_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      btn_prev   <= '0;
      start_prev <= 1'b0;
      turn_prev  <= 1'b0;
      score_q    <= '0;
      num_q      <= '0;
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev   <= btn_lvl;
      start_prev <= start_lvl[0];
      turn_prev  <= simon_turn;
      if (accept) num_q <= onehot_index(btn_lvl);

      if (state_q == ST_START) begin
        score_q <= '0;
      end else if (state_q == ST_PLAY && simon_turn && !turn_prev && score_q != SCORE_MAX) begin
        score_q <= score_q + 4'd1;
      end

      // Hold timer restarts on every entry into OVER and latches when done.
      if (state_q != ST_OVER) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if (!hold_done) begin
        if (hold_cnt == HOLD_LAST) hold_done <= 1'b1;
        else                       hold_cnt  <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
